// File: rtl/lms2lab_mac_seq_pkg.sv
// Shared constants for the log-LMS -> lab MAC sequencer: widths, the
// Q3.13 coefficient matrix and the sequencer state encoding.
package lab_pkg;

  localparam int DW   = 16;   // data / coefficient width, Q3.13
  localparam int FRAC = 13;   // fractional bits, selects the output slice
  localparam int ACCW = 33;   // signed accumulator, Q7.26

  // LMS -> lab matrix, rows l/a/b, columns L/M/S
  localparam logic [DW-1:0] M11 = 16'h127A;
  localparam logic [DW-1:0] M12 = 16'h127A;
  localparam logic [DW-1:0] M13 = 16'h127A;
  localparam logic [DW-1:0] M21 = 16'h0D10;
  localparam logic [DW-1:0] M22 = 16'h0D10;
  localparam logic [DW-1:0] M23 = 16'hE5DF;
  localparam logic [DW-1:0] M31 = 16'h16A1;
  localparam logic [DW-1:0] M32 = 16'hE95F;
  localparam logic [DW-1:0] M33 = 16'h0000;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Coefficient lookup by (row, col); unused codes return zero
  function automatic logic [DW-1:0] coef(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    coef = M11;
      4'h1:    coef = M12;
      4'h2:    coef = M13;
      4'h4:    coef = M21;
      4'h5:    coef = M22;
      4'h6:    coef = M23;
      4'h8:    coef = M31;
      4'h9:    coef = M32;
      4'hA:    coef = M33;
      default: coef = '0;
    endcase
  endfunction

endpackage

// File: rtl/lms2lab_mac_seq_mac.sv
// Registered signed multiply-accumulate shared by all three matrix rows.
// acc_nxt exposes the running sum including the current product so the
// caller can capture a row result on the same edge that clears the register.
module lab_mac #(
  parameter int AW   = 16,
  parameter int BW   = 17,
  parameter int ACCW = 33
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [AW-1:0]   a,
  input  logic signed [BW-1:0]   b,
  output logic signed [ACCW-1:0] acc_nxt
);

  logic signed [AW+BW-1:0] prod;
  logic signed [ACCW-1:0]  acc;

  assign prod    = a * b;
  assign acc_nxt = acc + ACCW'(prod);

  // Accumulator register: clear wins over enable
  always_ff @(posedge i_clk) begin
    if (i_rst || clr) acc <= '0;
    else if (en)      acc <= acc_nxt;
  end

endmodule

// File: rtl/lms2lab_mac_seq.sv
// Time-multiplexed log-LMS -> lab transform: one shared 16x17 MAC walks the
// 3x3 matrix row by row, results are published together on entry to DONE.
module lms2lab_mac_seq
  import lab_pkg::*;
#(
  parameter int DW        = lab_pkg::DW,
  parameter int FRAC      = lab_pkg::FRAC,
  parameter int ACCW      = lab_pkg::ACCW,
  parameter int SKIP_ZERO = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_logL,
  input  logic [DW-1:0] i_logM,
  input  logic [DW-1:0] i_logS,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_l,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic          o_busy
);

  state_t                 state;
  logic [1:0]             row, col;
  logic [DW:0]            xl, xm, xs;     // inputs zero-extended to signed 17b
  logic [DW-1:0]          res0, res1;     // rows l and a, held until DONE
  logic [DW-1:0]          cf;
  logic [DW:0]            xv;
  logic                   last;
  logic [1:0]             col_step;
  logic signed [ACCW-1:0] acc_nxt;
  logic [DW-1:0]          slice;

  // A step is bypassed only when skipping is enabled and its coefficient is zero
  function automatic logic skip(input logic [1:0] r, input logic [1:0] c);
    return (SKIP_ZERO != 0) && (coef(r, c) == '0);
  endfunction

  // First non-skipped column of a row
  function automatic logic [1:0] first_col(input logic [1:0] r);
    if (!skip(r, 2'd0))      return 2'd0;
    else if (!skip(r, 2'd1)) return 2'd1;
    else                     return 2'd2;
  endfunction

  // Operand select and end-of-row detection for the current step
  always_comb begin
    cf       = coef(row, col);
    xv       = (col == 2'd0) ? xl : (col == 2'd1) ? xm : xs;
    last     = (col == 2'd2) || ((col == 2'd1) && skip(row, 2'd2));
    col_step = ((col == 2'd0) && skip(row, 2'd1)) ? 2'd2 : 2'(col + 2'd1);
  end

  assign slice   = acc_nxt[FRAC+DW-1:FRAC];
  assign o_ready = (state == IDLE) && !i_rst;
  assign o_busy  = (state != IDLE);

  logic unused_acc;
  assign unused_acc = ^{acc_nxt[ACCW-1:FRAC+DW], acc_nxt[FRAC-1:0]};

  lab_mac #(.AW(DW), .BW(DW+1), .ACCW(ACCW)) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clr     ((state != MAC) || last),
    .en      (state == MAC),
    .a       (cf),
    .b       (xv),
    .acc_nxt (acc_nxt)
  );

  // Sequencer: accept a triple, walk the matrix, hold the result until drained
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_l     <= '0;
      o_a     <= '0;
      o_b     <= '0;
      row     <= '0;
      col     <= '0;
      xl      <= '0;
      xm      <= '0;
      xs      <= '0;
      res0    <= '0;
      res1    <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          xl    <= {1'b0, i_logL};
          xm    <= {1'b0, i_logM};
          xs    <= {1'b0, i_logS};
          row   <= 2'd0;
          col   <= first_col(2'd0);
          state <= MAC;
        end
        MAC: if (last) begin
          case (row)
            2'd0: begin
              res0 <= slice;
              row  <= 2'd1;
              col  <= first_col(2'd1);
            end
            2'd1: begin
              res1 <= slice;
              row  <= 2'd2;
              col  <= first_col(2'd2);
            end
            default: begin
              o_l     <= res0;
              o_a     <= res1;
              o_b     <= slice;
              o_valid <= 1'b1;
              row     <= 2'd0;
              col     <= 2'd0;
              state   <= DONE;
            end
          endcase
        end else begin
          col <= col_step;
        end
        DONE: if (i_ready) begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms2lab_mac_seq.sv
// Randomised bench for lms2lab_mac_seq: two instances (skip off / on) share
// the stimulus; results are checked against a plain integer matrix model.
module tb_lms2lab_mac_seq;

  logic        clk = 1'b0;
  logic        rst, vld, rdy;
  logic [15:0] L, M, S;
  logic        ordy0, ovld0, busy0, ordy1, ovld1, busy1;
  logic [15:0] l0, a0, b0, l1, a1, b1;

  int checks = 0;
  int errors = 0;

  // Signed matrix entries in units of 2^-13
  int cm [9] = '{4730, 4730, 4730, 3344, 3344, -6689, 5793, -5793, 0};

  always #5 clk = ~clk;

  lms2lab_mac_seq #(.SKIP_ZERO(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(ordy0),
    .i_logL(L), .i_logM(M), .i_logS(S), .o_valid(ovld0), .i_ready(rdy),
    .o_l(l0), .o_a(a0), .o_b(b0), .o_busy(busy0));

  lms2lab_mac_seq #(.SKIP_ZERO(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(ordy1),
    .i_logL(L), .i_logM(M), .i_logS(S), .o_valid(ovld1), .i_ready(rdy),
    .o_l(l1), .o_a(a1), .o_b(b1), .o_busy(busy1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Row result: floor(sum / 2^13), low 16 bits
  function automatic logic [15:0] model(input int r, input logic [15:0] x0,
                                        input logic [15:0] x1, input logic [15:0] x2);
    longint s;
    s = longint'(cm[r*3]) * longint'(x0) + longint'(cm[r*3+1]) * longint'(x1)
      + longint'(cm[r*3+2]) * longint'(x2);
    return 16'(s >>> 13);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Hand a triple in, wait for both results; leaves both instances in DONE
  task automatic launch(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
    int lat0, lat1;
    L = x0; M = x1; S = x2; vld = 1'b1; rdy = 1'b0;
    step();
    vld = 1'b0;
    lat0 = 0; lat1 = 0;
    for (int c = 1; c <= 30 && lat0 == 0; c++) begin
      step();
      if (ovld1 && lat1 == 0) lat1 = c;
      if (ovld0 && lat0 == 0) lat0 = c;
    end
    chk("lat0", lat0, 9);
    chk("lat1", lat1, 8);
    chk("l0", l0, model(0, x0, x1, x2));
    chk("a0", a0, model(1, x0, x1, x2));
    chk("b0", b0, model(2, x0, x1, x2));
    chk("l1", l1, model(0, x0, x1, x2));
    chk("a1", a1, model(1, x0, x1, x2));
    chk("b1", b1, model(2, x0, x1, x2));
    chk("rdy_done", {ordy0, ordy1}, 2'b00);
  endtask

  task automatic drain();
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("drain_vld", {ovld0, ovld1}, 2'b00);
    chk("drain_rdy", {ordy0, ordy1}, 2'b11);
  endtask

  initial begin
    logic [15:0] hl, ha, hb;
    rst = 1'b1; vld = 1'b0; rdy = 1'b0; L = '0; M = '0; S = '0;
    step(); step();
    chk("rst_rdy", {ordy0, ordy1}, 2'b00);
    chk("rst_out", {ovld0, l0, a0, b0}, '0);
    rst = 1'b0;
    step();
    chk("idle_rdy", {ordy0, ordy1, busy0, busy1}, 4'b1100);

    // Directed corners
    launch(16'h2000, 16'h2000, 16'h2000);
    chk("one_l", l0, 16'h376E);
    chk("one_a", a0, 16'hFFFF);
    chk("one_b", b0, 16'h0000);
    drain(); step();
    launch(16'h2000, 16'h0000, 16'h0000);
    chk("col1", {l0, a0, b0}, {16'h127A, 16'h0D10, 16'h16A1});
    drain(); step();
    launch(16'hFFFF, 16'hFFFF, 16'hFFFF);
    chk("wrap_l", l0, 16'hBB6E);

    // Backpressure: hold DONE and offer a new triple that must be ignored
    hl = l0; ha = a0; hb = b0;
    vld = 1'b1; L = 16'h1234; M = 16'h5678; S = 16'h9ABC;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_vld", {ovld0, ovld1}, 2'b11);
      chk("bp_hold", {l0, a0, b0}, {hl, ha, hb});
      chk("bp_rdy", {ordy0, ordy1}, 2'b00);
    end
    vld = 1'b0;
    drain();
    chk("bp_after", {busy0, l0}, {1'b0, hl});
    step();
    chk("bp_noacc", {busy0, busy1}, 2'b00);

    // Reset mid-computation
    L = 16'h2000; M = 16'h2000; S = 16'h2000; vld = 1'b1;
    step();
    vld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out", {busy0, busy1, ovld0, ovld1, l0, a0, b0, l1}, '0);
    step();
    launch(16'h2000, 16'h2000, 16'h2000);
    chk("post_rst", {l0, a0, b0}, {16'h376E, 16'hFFFF, 16'h0000});
    drain(); step();

    // Random triples
    for (int n = 0; n < 25; n++) begin
      launch(16'($urandom), 16'($urandom), 16'($urandom));
      drain();
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lms2lab_mac_seq.md
Name: lms2lab_mac_seq

Overview:
Time-multiplexed sequencer for the log-LMS to lab colour transform in the RGB2lab chain. It evaluates the 3x3 matrix product with one shared signed 16x17 multiplier and a 33-bit accumulator, stepping through the coefficients over successive cycles. It replaces three parallel 3-term dot products with one MAC plus a small FSM. Input and output use valid/ready handshakes, so it sits between the log stage and the downstream colour-statistics stage.

Parameters:
DW, 16, data/coefficient width (Q3.13)
FRAC, 13, fractional bits, which set the output slice position
ACCW, 33, accumulator width (signed, Q7.26)
SKIP_ZERO, 0, when 1, skip MAC steps whose coefficient is zero (currently only m33)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  input triple valid
o_ready  out  1  block can accept a triple
i_logL  in  16  log L, unsigned Q3.13
i_logM  in  16  log M, unsigned Q3.13
i_logS  in  16  log S, unsigned Q3.13
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_l  out  16  l, signed Q3.13
o_a  out  16  a, signed Q3.13
o_b  out  16  b, signed Q3.13
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous. While i_rst is high at a clock edge: state=IDLE, o_valid=0, o_ready=0 in that cycle, o_l/o_a/o_b=0, accumulator=0, step counter=0, and input latches cleared.
- States:
  - IDLE: o_ready=1. On i_valid&&o_ready, latch the triple, zero-extended to 17 bits as {1'b0,x}. Go to MAC, with row=0, col=0 and the accumulator cleared.
  - MAC: one product per cycle.
    - Each cycle: acc += $signed(coef[row][col]) * $signed(x[col]), with col=0/1/2 selecting L/M/S.
    - When col==2: write acc_next[28:13] to the result register for that row (0=l, 1=a, 2=b), clear acc, set col=0 and advance row.
    - After row 2, col 2: go to DONE.
    - With SKIP_ZERO=1, steps whose coefficient equals 0 are bypassed without spending a cycle. This makes 8 MAC cycles with the current table.
  - DONE: o_valid=1. o_l/o_a/o_b are held stable until i_valid... correction: until i_ready. On i_ready: o_valid drops next cycle and state returns to IDLE.
- o_ready is 0 in MAC and DONE, so no new input is accepted until the result is drained. There is no input skid.
- Latency: an input accepted at edge 0 gives o_valid=1 after edge 9 (SKIP_ZERO=0) or after edge 8 (SKIP_ZERO=1).
- Minimum initiation interval: 11 cycles (or 10), which includes 1 DONE cycle and 1 IDLE cycle.
- Arithmetic:
  - Signed product is 33 bits and the sum is kept in ACCW.
  - Output is bits [FRAC+15:FRAC], i.e. truncation toward minus infinity.
  - There is no saturation: overflow wraps to the low 16 bits of the slice.
- o_l/o_a/o_b change only on the transition into DONE. They keep their last value while in IDLE and MAC.
- i_valid in MAC or DONE is ignored. The upstream stage must hold its data because o_ready=0.
- Reset asserted mid-MAC or in DONE aborts immediately. The partial result is discarded and all outputs return to their reset values.
- i_ready low in DONE: hold indefinitely with outputs stable.

Decomposition:
- Package lab_pkg holds:
  - DW, FRAC, ACCW
  - the coefficient table as 9 localparam 16-bit constants in Q3.13:
    - m11=m12=m13=16'h127A
    - m21=m22=16'h0D10, m23=16'hE5DF
    - m31=16'h16A1, m32=16'hE95F, m33=16'h0000
  - the state enum {IDLE, MAC, DONE}
- One sub-module, lab_mac: registered signed multiply-accumulate with clear and enable inputs, shared by all three rows.
- The FSM, step counter and result registers live in the top module.

Test Plan:
- L=M=S=16'h2000 (1.0) -> o_l=16'h376E, o_a=16'hFFFF, o_b=16'h0000. o_valid rises 9 cycles after the handshake.
- L=16'h2000, M=S=0 -> o_l=16'h127A, o_a=16'h0D10, o_b=16'h16A1.
- L=M=S=16'hFFFF -> o_l=16'hBB6E. This checks wrap (no saturation) and the unsigned zero-extension of the inputs.
- Backpressure: hold i_ready=0 for 20 cycles in DONE. Expect o_valid to stay 1, outputs stable, o_ready=0, and a new i_valid ignored. Release i_ready and expect IDLE and o_ready=1 after 1 cycle.
- Reset pulse at MAC step 4 -> next cycle shows IDLE, outputs 0 and o_valid=0. A subsequent 1.0/1.0/1.0 input gives the correct 16'h376E/16'hFFFF/16'h0000.
- SKIP_ZERO=1 with L=M=S=16'h2000 -> same results as the first case, with o_valid 8 cycles after the handshake.
